serdesphy_word_packer: RTL and testbench
========================================

SERDESPHY_WORD_PACKER -- requirements
Module: serdesphy_word_packer

Interface
REQ-001 Parameter IN_W, default 4, the input slice width in bits; SHALL be at least 1.
REQ-002 Parameter RATIO, default 2, the number of slices per output word; SHALL be at least 2.
REQ-003 Parameter MSB_FIRST, default 0; 0 places the first slice in the LSBs, 1 places it in the MSBs.
REQ-004 Derived width OUT_W = IN_W*RATIO.
REQ-005 Port clk, input, 1 bit: 24 MHz clock; the block SHALL have this single clock.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port in_data, input, IN_W bits: transmit slice.
REQ-008 Port in_valid, input, 1 bit: slice valid.
REQ-009 Port in_ready, output, 1 bit: slice accepted this cycle when high together with in_valid.
REQ-010 Port flush, input, 1 bit: discard the partial word.
REQ-011 Port out_data, output, OUT_W bits: assembled word.
REQ-012 Port out_valid, output, 1 bit: out_data is valid.
REQ-013 Port out_ready, input, 1 bit: consumer accepts the word.
REQ-014 Port partial, output, 1 bit: high when one or more slices of an incomplete word are held.
REQ-015 Port word_count, output, 16 bits: statistics counter (see Configuration).
REQ-016 Port drop_count, output, 8 bits: statistics counter (see Configuration).

Function
REQ-017 The block SHALL hold a slice counter cnt (0..RATIO-1), a partial-word register, and a 2-entry output FIFO with a fill count of 0..2.
REQ-018 A slice SHALL be accepted on a rising clk edge when in_valid=1 and in_ready=1; cnt then increments.
REQ-019 Slice k of a word SHALL be written to bits [k*IN_W +: IN_W] when MSB_FIRST=0.
REQ-020 Slice k of a word SHALL be written to bits [(RATIO-1-k)*IN_W +: IN_W] when MSB_FIRST=1.
REQ-021 Accepting a slice at cnt=RATIO-1 SHALL push the completed word into the FIFO on the same edge and return cnt to 0.
REQ-022 out_valid SHALL rise in the cycle immediately after the edge that accepts the last slice (1-cycle latency).
REQ-023 in_ready SHALL equal NOT flush AND NOT (cnt=RATIO-1 AND fill=2).
REQ-024 in_ready SHALL be combinational and SHALL NOT depend on out_ready or in_valid.
REQ-025 out_valid SHALL equal (fill != 0), and out_data SHALL be the FIFO head.
REQ-026 The FIFO SHALL pop on an edge where out_valid=1 and out_ready=1.
REQ-027 A simultaneous push and pop SHALL leave fill unchanged, and words SHALL emerge in push order.
REQ-028 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 flush=1 SHALL clear cnt and the partial register on the next edge; the FIFO contents SHALL be unaffected.
REQ-030 A slice presented while flush=1 SHALL be dropped.
REQ-031 partial SHALL equal (cnt != 0).
REQ-032 Gaps in in_valid SHALL be allowed; cnt SHALL hold its value across gaps indefinitely.

Reset
REQ-033 While rst_n=0, the block SHALL set cnt=0, fill=0, the partial register and FIFO storage to 0, and word_count=0 and drop_count=0.
REQ-034 Output values during reset SHALL be: out_valid=0, out_data=0, partial=0, in_ready=1.
REQ-035 Reset asserted mid-word or with a non-empty FIFO SHALL discard all held data, with no output after release.

Configuration
REQ-036 The block SHALL use the macro SERDESPHY_PACKER_STATS_EN to compile the statistics counters in or out.
REQ-037 With the macro defined, word_count SHALL increment by 1 per FIFO push, wrapping from 0xFFFF to 0.
REQ-038 With the macro defined, drop_count SHALL increment when flush=1 at an edge with cnt!=0, saturating at 0xFF.
REQ-039 Without the macro, word_count and drop_count SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-040 Defaults, out_ready=1; slices 0xA then 0x5 -> out_data=0x5A, out_valid high exactly 1 cycle, 1 cycle after the second slice is accepted.
REQ-041 MSB_FIRST=1; slices 0xA then 0x5 -> out_data=0xA5.
REQ-042 IN_W=4, RATIO=4; slices 0x1,0x2,0x3,0x4 -> out_data=0x4321; partial=1 after the first slice and 0 after the fourth.
REQ-043 out_ready=0; six slices 1..6 offered back-to-back -> fill=2 holding 0x21 and 0x43; in_ready low while 0x6 is presented; releasing out_ready -> 0x21, 0x43, 0x65 in order.
REQ-044 Macro defined; slice 0x7, then flush, then slices 0x3 and 0xC -> out_data=0xC3 only, drop_count=1, word_count=1.
REQ-045 rst_n pulsed low after one slice with one word in the FIFO -> out_valid=0 and partial=0 immediately; slices 0x1 and 0x2 after release -> out_data=0x21.

Source files
------------

// File: rtl/serdesphy_word_packer.sv
// Packs RATIO slices of IN_W bits into one OUT_W word, then queues the word in a 2-entry output FIFO.
// The word_count/drop_count statistics exist only when SERDESPHY_PACKER_STATS_EN is defined.
module serdesphy_word_packer #(
    parameter int IN_W      = 4,
    parameter int RATIO     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [IN_W*RATIO-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    partial,
    output logic [15:0]             word_count,
    output logic [7:0]              drop_count
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    // Handshake: a transfer occurs on the rising edge where valid and ready are both high.
    // in_ready depends only on flush and internal state. out_valid/out_data stay stable until popped.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] part_q, part_d;
    logic [OUT_W-1:0] word_w;
    logic [OUT_W-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       fill_q, fill_d;
    logic             last, accept, push, pop;
    logic [CNT_W-1:0] slot;

    assign last      = (cnt_q == LAST);
    assign in_ready  = !flush && !(last && (fill_q == 2'd2));
    assign accept    = in_valid && in_ready;
    assign push      = accept && last;
    assign out_valid = (fill_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign partial   = (cnt_q != '0);
    assign slot      = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

    always_comb begin
        word_w = part_q;
        word_w[int'(slot) * IN_W +: IN_W] = in_data;
        cnt_d  = cnt_q;
        part_d = part_q;
        if (flush) begin
            cnt_d  = '0;
            part_d = '0;
        end else if (accept) begin
            if (last) begin
                cnt_d  = '0;
                part_d = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                part_d = word_w;
            end
        end
        // push into a full FIFO cannot happen: in_ready blocks the last slice in that case
        fill_d = fill_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            part_q   <= '0;
            fill_q   <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            part_q <= part_d;
            fill_q <= fill_d;
            if (push) begin
                mem_q[wr_ptr_q] <= word_w;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef SERDESPHY_PACKER_STATS_EN
    logic [15:0] word_count_q;
    logic [7:0]  drop_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            if (push) begin
                word_count_q <= word_count_q + 16'd1;
            end
            // only a flush that actually discards held slices counts as a drop
            if (flush && partial && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign word_count = word_count_q;
    assign drop_count = drop_count_q;
`else
    assign word_count = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_serdesphy_word_packer.sv
// Directed bench for serdesphy_word_packer: default, MSB-first and RATIO=4 instances.
// Counter expectations follow SERDESPHY_PACKER_STATS_EN (zero when it is undefined).
module tb_serdesphy_word_packer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef SERDESPHY_PACKER_STATS_EN
    localparam logic [31:0] EXP_WC = 32'd1;
    localparam logic [31:0] EXP_DC = 32'd1;
`else
    localparam logic [31:0] EXP_WC = 32'd0;
    localparam logic [31:0] EXP_DC = 32'd0;
`endif

    // default instance
    logic [3:0]  a_in_data;
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_partial;
    logic [7:0]  a_out_data;
    logic [15:0] a_wc;
    logic [7:0]  a_dc;
    // MSB-first instance
    logic [3:0]  m_in_data;
    logic        m_in_valid, m_in_ready, m_flush, m_out_valid, m_out_ready, m_partial;
    logic [7:0]  m_out_data;
    logic [15:0] m_wc;
    logic [7:0]  m_dc;
    // RATIO=4 instance
    logic [3:0]  r_in_data;
    logic        r_in_valid, r_in_ready, r_flush, r_out_valid, r_out_ready, r_partial;
    logic [15:0] r_out_data;
    logic [15:0] r_wc;
    logic [7:0]  r_dc;

    serdesphy_word_packer u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .partial(a_partial),
        .word_count(a_wc), .drop_count(a_dc)
    );

    serdesphy_word_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .flush(m_flush), .out_data(m_out_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .partial(m_partial),
        .word_count(m_wc), .drop_count(m_dc)
    );

    serdesphy_word_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(1'b0)) u_r4 (
        .clk(clk), .rst_n(rst_n), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_ready(r_in_ready), .flush(r_flush), .out_data(r_out_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .partial(r_partial),
        .word_count(r_wc), .drop_count(r_dc)
    );

    typedef struct {
        logic [3:0] din;
        logic       vld;
        logic       fl;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ir;
        logic       e_p;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        m_in_data = '0; m_in_valid = 1'b0; m_flush = 1'b0; m_out_ready = 1'b1;
        r_in_data = '0; r_in_valid = 1'b0; r_flush = 1'b0; r_out_ready = 1'b1;

        //           din   vld   fl    ordy  e_ov  e_od   e_ir  e_p
        vec[0]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[1]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[2]  = '{4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vec[3]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        vec[4]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[5]  = '{4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[6]  = '{4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vec[7]  = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0};
        vec[8]  = '{4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b1};
        vec[9]  = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0};
        vec[10] = '{4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1};
        vec[11] = '{4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1};
        vec[12] = '{4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1};
        vec[13] = '{4'h6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1, 1'b1};
        vec[14] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h65, 1'b1, 1'b0};
        vec[15] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        // outputs while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", a_out_valid, 0);
        check("rst out_data", a_out_data, 0);
        check("rst partial", a_partial, 0);
        check("rst in_ready", a_in_ready, 1);
        check("rst word_count", a_wc, 0);
        check("rst drop_count", a_dc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // table: single word, then back-pressure fill/drain ordering
        for (int i = 0; i < NV; i++) begin
            a_in_data   = vec[i].din;
            a_in_valid  = vec[i].vld;
            a_flush     = vec[i].fl;
            a_out_ready = vec[i].ordy;
            @(negedge clk);
            check($sformatf("v%0d in_ready", i), a_in_ready, vec[i].e_ir);
            check($sformatf("v%0d out_valid", i), a_out_valid, vec[i].e_ov);
            check($sformatf("v%0d partial", i), a_partial, vec[i].e_p);
            if (vec[i].e_ov) check($sformatf("v%0d out_data", i), a_out_data, vec[i].e_od);
            tick();
        end
        a_in_valid = 1'b0;

        // flush discards a partial word; a slice under flush is dropped
        do_reset();
        a_out_ready = 1'b1;
        a_in_data = 4'h7; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0; a_flush = 1'b1;
        @(negedge clk);
        check("fl in_ready", a_in_ready, 0);
        check("fl partial held", a_partial, 1);
        tick();
        a_in_data = 4'hF; a_in_valid = 1'b1;
        @(negedge clk);
        check("fl partial cleared", a_partial, 0);
        check("fl slice blocked", a_in_ready, 0);
        tick();
        a_flush = 1'b0; a_in_data = 4'h3;
        tick();
        a_in_data = 4'hC;
        @(negedge clk);
        check("fl partial after 3", a_partial, 1);
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("fl out_valid", a_out_valid, 1);
        check("fl out_data", a_out_data, 32'hC3);
        check("fl word_count", a_wc, EXP_WC);
        check("fl drop_count", a_dc, EXP_DC);
        tick();
        @(negedge clk);
        check("fl single word", a_out_valid, 0);

        // reset mid-word with a word queued
        do_reset();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 4'h1; tick();
        a_in_data = 4'h2; tick();
        a_in_data = 4'h3; tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("mr queued valid", a_out_valid, 1);
        check("mr queued partial", a_partial, 1);
        rst_n = 1'b0;
        #1;
        check("mr out_valid", a_out_valid, 0);
        check("mr partial", a_partial, 0);
        check("mr in_ready", a_in_ready, 1);
        check("mr out_data", a_out_data, 0);
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("mr no output", a_out_valid, 0);
        a_in_valid = 1'b1;
        a_in_data = 4'h1; tick();
        a_in_data = 4'h2; tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        check("mr new valid", a_out_valid, 1);
        check("mr new data", a_out_data, 32'h21);

        // MSB-first placement
        do_reset();
        m_in_valid = 1'b1;
        m_in_data = 4'hA; tick();
        m_in_data = 4'h5; tick();
        m_in_valid = 1'b0;
        @(negedge clk);
        check("msb out_valid", m_out_valid, 1);
        check("msb out_data", m_out_data, 32'hA5);
        tick();
        @(negedge clk);
        check("msb popped", m_out_valid, 0);

        // four slices per word
        do_reset();
        r_in_valid = 1'b1;
        r_in_data = 4'h1; tick();
        @(negedge clk);
        check("r4 partial first", r_partial, 1);
        check("r4 no early valid", r_out_valid, 0);
        r_in_data = 4'h2; tick();
        r_in_data = 4'h3; tick();
        r_in_data = 4'h4; tick();
        r_in_valid = 1'b0;
        @(negedge clk);
        check("r4 partial last", r_partial, 0);
        check("r4 out_valid", r_out_valid, 1);
        check("r4 out_data", r_out_data, 32'h4321);
        tick();
        @(negedge clk);
        check("r4 popped", r_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
